// File: rtl/btn_toggle_pulse_pkg.sv
// Shared definitions for the push-button conditioning blocks: FSM state
// encodings, default debounce length and a small state-decode helper.
package btn_toggle_pulse_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_t;

  localparam int DEFAULT_CNT_W           = 16;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

  // The debounced level is high whenever the button is considered held,
  // including while a release is still being confirmed.
  function automatic logic is_level_high(input btn_state_t s);
    return (s == PRESSED) || (s == RELEASE_CHK);
  endfunction

endpackage

// File: rtl/btn_toggle_pulse_sync_2ff.sv
// 1-bit two-stage synchroniser for asynchronous inputs; synchronous
// active-high reset clears both stages.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/btn_toggle_pulse.sv
// Push-button conditioner: synchronise, debounce, and emit one en_pulse per
// accepted press (plus optional auto-repeat) and one rel_pulse per release.
module btn_toggle_pulse
  import btn_toggle_pulse_pkg::*;
#(
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       en_pulse,
  output logic       rel_pulse,
  output logic [1:0] dbg_state
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic btn_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  btn_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] rcnt, rcnt_n;
  logic             rep_done, rep_done_n;
  logic             en_n, rel_n;

  // rep_done marks that the first auto-repeat has fired, so rcnt switches
  // from the initial delay to the period (or freezes when the period is 0).
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rcnt_n     = rcnt;
    rep_done_n = rep_done;
    en_n       = 1'b0;
    rel_n      = 1'b0;
    case (state)
      RELEASED: begin
        if (btn_s) begin
          state_n = PRESS_CHK;
          cnt_n   = '0;
        end
      end
      PRESS_CHK: begin
        if (!btn_s) begin
          state_n = RELEASED;
        end else if (cnt == DB_LAST) begin
          state_n    = PRESSED;
          en_n       = 1'b1;
          rcnt_n     = '0;
          rep_done_n = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_n = RELEASE_CHK;
          cnt_n   = '0;
        end else if (REPEAT_DELAY != 0) begin
          if (!rep_done) begin
            if (rcnt == RD_LAST) begin
              en_n       = 1'b1;
              rcnt_n     = '0;
              rep_done_n = 1'b1;
            end else begin
              rcnt_n = rcnt + 1'b1;
            end
          end else if (REPEAT_PERIOD != 0) begin
            if (rcnt == RP_LAST) begin
              en_n   = 1'b1;
              rcnt_n = '0;
            end else begin
              rcnt_n = rcnt + 1'b1;
            end
          end
        end
      end
      RELEASE_CHK: begin
        // A bounce back to pressed keeps rcnt, so repeat timing is not restarted.
        if (btn_s) begin
          state_n = PRESSED;
        end else if (cnt == DB_LAST) begin
          state_n = RELEASED;
          rel_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = RELEASED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RELEASED;
      cnt       <= '0;
      rcnt      <= '0;
      rep_done  <= 1'b0;
      en_pulse  <= 1'b0;
      rel_pulse <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rcnt      <= rcnt_n;
      rep_done  <= rep_done_n;
      en_pulse  <= en_n;
      rel_pulse <= rel_n;
      btn_level <= is_level_high(state_n);
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_btn_toggle_pulse.sv
// Directed bench for btn_toggle_pulse with DEBOUNCE_CYCLES=4: reset, bounce,
// press/release timing, release glitch, reset mid-press, T-flop chain, auto-repeat.
module tb_btn_toggle_pulse;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst;
  logic btn, btn_r;
  logic lvl, en, rel;
  logic lvl_r, en_r, rel_r;
  logic lvl_s, en_s, rel_s;
  logic [1:0] st, st_r, st_s;
  logic t_out;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   overlap  = 0;
  logic [7:0] exp_q_r[$];
  logic [7:0] exp_q_s[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  btn_toggle_pulse #(.CNT_W(16), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(0), .REPEAT_PERIOD(0)) dut (
    .clk(clk), .rst(rst), .btn_in(btn),
    .btn_level(lvl), .en_pulse(en), .rel_pulse(rel), .dbg_state(st)
  );

  btn_toggle_pulse #(.CNT_W(16), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut_r (
    .clk(clk), .rst(rst), .btn_in(btn_r),
    .btn_level(lvl_r), .en_pulse(en_r), .rel_pulse(rel_r), .dbg_state(st_r)
  );

  btn_toggle_pulse #(.CNT_W(16), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(6), .REPEAT_PERIOD(0)) dut_s (
    .clk(clk), .rst(rst), .btn_in(btn_r),
    .btn_level(lvl_s), .en_pulse(en_s), .rel_pulse(rel_s), .dbg_state(st_s)
  );

  // Downstream T-switch: toggles once per en_pulse.
  always @(posedge clk) begin
    if (rst) t_out <= 1'b0;
    else if (en) t_out <= ~t_out;
  end

  always @(posedge clk) begin
    if ((en && rel) || (en_r && rel_r) || (en_s && rel_s)) overlap <= overlap + 1;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({lvl, en, rel});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Input driven just after an edge is sampled at the next edge (k);
  // the pulse appears after edge k+DB+2, i.e. the 7th tick here.
  task automatic press_and_check(input string tag);
    btn = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check(tag, outs(), (i == 7) ? 32'd6 : (i > 7) ? 32'd4 : 32'd0);
    end
  endtask

  task automatic release_and_check(input string tag);
    btn = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check(tag, outs(), (i == 7) ? 32'd1 : (i > 7) ? 32'd0 : 32'd4);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic exp_en_r, exp_en_s, exp_lvl;
    rst   = 1'b1;
    btn   = 1'b0;
    btn_r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_outs", outs(), 32'd0);
      check("reset_state", 32'(st), 32'd0);
    end
    rst = 1'b0;

    // Bounce: alternate every cycle, never stable long enough.
    for (int i = 0; i < 12; i++) begin
      btn = (i % 2 == 0);
      tick();
      check("bounce", outs(), 32'd0);
    end
    btn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bounce_tail", outs(), 32'd0);
    end

    press_and_check("clean_press");
    for (int i = 0; i < 11; i++) begin
      tick();
      check("hold", outs(), 32'd4);
    end

    // Two-cycle release glitch must be absorbed.
    btn = 1'b0;
    tick();
    tick();
    btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rel_glitch", outs(), 32'd4);
    end

    release_and_check("release");
    check("idle_state", 32'(st), 32'd0);

    // Reset in the middle of PRESS_CHK aborts; held button re-debounces.
    btn = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("mid_state", 32'(st), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_outs", outs(), 32'd0);
    check("mid_rst_state", 32'(st), 32'd0);
    tick();
    check("mid_rst_outs2", outs(), 32'd0);
    rst = 1'b0;
    press_and_check("held_after_rst");
    check("tsw_1", 32'(t_out), 32'd1);
    release_and_check("tsw_rel1");
    press_and_check("tsw_press2");
    check("tsw_2", 32'(t_out), 32'd0);
    release_and_check("tsw_rel2");
    press_and_check("tsw_press3");
    check("tsw_3", 32'(t_out), 32'd1);
    release_and_check("tsw_rel3");

    // Auto-repeat: acceptance at tick 7, then +10 and every +5 while held.
    exp_q_r = '{8'd7, 8'd17, 8'd22, 8'd27, 8'd32, 8'd37, 8'd42};
    exp_q_s = '{8'd7, 8'd13};
    btn_r = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      exp_en_r = (exp_q_r.size() != 0) && (exp_q_r[0] == 8'(i));
      if (exp_en_r) void'(exp_q_r.pop_front());
      exp_en_s = (exp_q_s.size() != 0) && (exp_q_s[0] == 8'(i));
      if (exp_en_s) void'(exp_q_s.pop_front());
      exp_lvl = (i >= 7) && (i < 51);
      check("repeat_r", 32'({lvl_r, en_r, rel_r}), 32'({exp_lvl, exp_en_r, i == 51}));
      check("repeat_s", 32'({lvl_s, en_s, rel_s}), 32'({exp_lvl, exp_en_s, i == 51}));
      if (i == 44) btn_r = 1'b0;
    end
    check("repeat_r_q_empty", 32'(exp_q_r.size()), 32'd0);
    check("repeat_s_q_empty", 32'(exp_q_s.size()), 32'd0);
    check("repeat_r_state", 32'(st_r), 32'd0);
    check("repeat_s_state", 32'(st_s), 32'd0);
    check("pulse_overlap", 32'(overlap), 32'd0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_toggle_pulse.md
Name: btn_toggle_pulse

Overview:
- Upstream conditioning stage for the T-switch toggle cell.
- Takes a raw, asynchronous, bouncing push-button and synchronises and debounces it.
- Emits a single-cycle `en_pulse` per accepted press. Optional auto-repeat while the button is held.
- `en_pulse` drives the T-switch `en` input directly, on the same `clk`, so one press gives exactly one toggle.

Parameters:
- CNT_W, 16: width of the debounce and repeat counters. Must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronised cycles needed to accept a level change. Must be >= 1.
- REPEAT_DELAY, 0: cycles in PRESSED before the first auto-repeat pulse. 0 disables auto-repeat.
- REPEAT_PERIOD, 0: cycles between subsequent repeat pulses. 0 means single repeat only, after REPEAT_DELAY.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  reset, synchronous, active-high
- btn_in  input  1  raw button, asynchronous to clk, active-high
- btn_level  output  1  debounced level; 1 in PRESSED/RELEASE_CHK
- en_pulse  output  1  one-cycle pulse on accepted press and on each auto-repeat
- rel_pulse  output  1  one-cycle pulse on accepted release

Behaviour:
- Clocking and reset:
  - One clock `clk`. Reset `rst` is synchronous and active-high.
  - While rst=1 at a rising edge: synchroniser FFs, counters, `btn_level`, `en_pulse` and `rel_pulse` are all 0; state = RELEASED.
- Synchroniser: 2-FF chain, btn_in -> s1 -> btn_s. No combinational path from btn_in to any output.
- FSM states: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK.
- RELEASED:
  - btn_s=1 -> PRESS_CHK, cnt=0.
- PRESS_CHK:
  - btn_s=0 -> RELEASED (bounce rejected, no pulse).
  - else if cnt==DEBOUNCE_CYCLES-1 -> PRESSED, en_pulse=1 next cycle, rcnt=0.
  - else cnt++.
- PRESSED:
  - btn_s=0 -> RELEASE_CHK, cnt=0.
  - else if REPEAT_DELAY!=0 -> rcnt counts.
    - rcnt==REPEAT_DELAY-1 (first repeat) or rcnt==REPEAT_PERIOD-1 (subsequent, only if REPEAT_PERIOD!=0): en_pulse=1, rcnt=0.
    - After the first repeat with REPEAT_PERIOD=0: rcnt frozen, no further pulses.
- RELEASE_CHK:
  - btn_s=1 -> PRESSED. No pulse. rcnt keeps its value, so the repeat timing is not restarted by a glitch.
  - else if cnt==DEBOUNCE_CYCLES-1 -> RELEASED, rel_pulse=1 next cycle.
  - else cnt++.
- Latency: btn_in high and stable from the cycle it is first sampled at edge k. en_pulse is high in the cycle following edge k+DEBOUNCE_CYCLES+2. Release latency is symmetric.
- Outputs:
  - All outputs registered. en_pulse and rel_pulse are exactly 1 cycle wide and never high together.
  - btn_level updates in the same cycle the pulse rises.
- Counter rules: unsigned CNT_W-bit counters; they never wrap (bounded by the compare).
- Reset corner cases:
  - Reset mid-debounce or mid-press aborts all activity; no pulse is emitted.
  - If the button is still held after reset deasserts, it is treated as a new press: full debounce, then one en_pulse.
- Minimum bounce: a btn_in glitch of 1 cycle may never produce a pulse for any DEBOUNCE_CYCLES >= 2.

Decomposition:
- Shared header btn_defs: FSM state encodings (2-bit: RELEASED=0, PRESS_CHK=1, PRESSED=2, RELEASE_CHK=3) and the default debounce constant.
- One sub-module, sync_2ff: 1-bit 2-stage synchroniser with clk/rst. Reused by later input-conditioning blocks.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 unless stated.
- Reset then clean press: rst=1 for 3 cycles, all outputs 0. btn_in=1 sampled at edge 10 -> en_pulse=1 only in the cycle after edge 16; btn_level=1 from then; exactly one pulse.
- Bounce rejection: btn_in toggled 1,0,1,0 on alternate cycles for 12 cycles, then 0 -> en_pulse and btn_level stay 0 throughout.
- Press/release pair: hold 20 cycles, release -> one en_pulse, then one rel_pulse 6 cycles after release is sampled; btn_level returns to 0 with it.
- Release glitch: while PRESSED, btn_in=0 for 2 cycles then 1 -> no rel_pulse, no extra en_pulse, btn_level stays 1.
- Auto-repeat (REPEAT_DELAY=10, REPEAT_PERIOD=5): hold 40 cycles after acceptance -> pulses at acceptance, +10, +15, +20, +25, +30, +35.
- Reset mid-press and T-switch chain: assert rst during PRESS_CHK -> no pulse, state RELEASED. Then 3 clean presses into a T_switch instance -> out sequence 1,0,1.
